mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/mux_settle_timer.sv | 38 +++
 rtl/mux_scan_ctrl.sv | 116 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Brief    : Shared types and constants for the 8:1 mux scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;
    localparam int CH_COUNT = 8;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;
endpackage

`default_nettype wire

// File: rtl/mux_settle_timer.sv
// ============================================================================
// Module   : mux_settle_timer
// Brief    : 4-bit settle counter; expire marks the last settle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expire = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module   : mux_scan_ctrl
// Brief    : Steps an external 8:1 mux through all channels and captures Y.
//            Define MUX_SCAN_CONT_EN for continuous rescanning after DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                Y,
    output logic [SEL_W-1:0]    S,
    output logic                busy,
    output logic                done,
    output logic [CH_COUNT-1:0] data_out
);

    scan_state_e         r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic [CH_COUNT-1:0] r_buf, w_buf_nxt;
    logic [CH_COUNT-1:0] r_data_out, w_data_out_nxt;
    logic                w_load;
    logic                w_expire;

    mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .en     (r_state == SETTLE),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_buf      <= '0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_buf      <= w_buf_nxt;
            r_data_out <= w_data_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_buf_nxt      = r_buf;
        w_data_out_nxt = r_data_out;
        w_load         = 1'b0;

        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        w_state_nxt = SETTLE;
                        w_sel_nxt   = '0;
                        w_load      = 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        w_state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    w_buf_nxt[r_sel] = Y;
                    // Increment wraps 7 -> 0, so S is already 0 in DONE
                    w_sel_nxt        = r_sel + SEL_W'(1);
                    if (r_sel == SEL_W'(CH_COUNT - 1)) begin
                        w_state_nxt    = DONE;
                        w_data_out_nxt = w_buf_nxt;
                    end else begin
                        w_state_nxt = SETTLE;
                        w_load      = 1'b1;
                    end
                end
                DONE: begin
                    w_sel_nxt = '0;
`ifdef MUX_SCAN_CONT_EN
                    w_state_nxt = SETTLE;
                    w_load      = 1'b1;
`else
                    w_state_nxt = IDLE;
`endif
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                end
            endcase
        end
    end

    assign S        = r_sel;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Brief    : Self-checking bench for mux_scan_ctrl (SETTLE_CYCLES 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, abort1 = 1'b0, y1;
    logic       start3 = 1'b0, abort3 = 1'b0, y3;
    logic [2:0] s1, s3;
    logic       busy1, done1, busy3, done3;
    logic [7:0] dout1, dout3;
    logic [7:0] i1 = 8'h00, i3 = 8'h00;
    bit         poison3 = 1'b0;
    int         k3 = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q1[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux models; the SETTLE_CYCLES=3 model drives the wrong value except on
    // the cycle that ends at a legal sampling edge.
    assign y1 = i1[s1];
    assign y3 = (poison3 && (((cyc + 1 - k3) % 4) != 0)) ? ~i3[s3] : i3[s3];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .Y(y1),
        .S(s1), .busy(busy1), .done(done1), .data_out(dout1)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .Y(y3),
        .S(s3), .busy(busy3), .done(done3), .data_out(dout3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb1_unexpected_done: got done data 0x%0h expected no done", dout1);
            end else begin
                check("sb1_data_out", dout1, q1.pop_front());
            end
        end
        if (rst_n && done3) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb3_unexpected_done: got done data 0x%0h expected no done", dout3);
            end else begin
                check("sb3_data_out", dout3, q3.pop_front());
            end
        end
    end

    task automatic pulse_start1();
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic wait_sel1(input logic [2:0] sel, output bit found);
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (s1 == sel) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_scan1(input logic [7:0] pat, input bit restart, input logic [7:0] exp);
        int         k;
        int         dcyc;
        logic [7:0] seen;
        logic [7:0] prev;
        bit         leak;
        bit         drop;
        prev = dout1;
        seen = '0;
        dcyc = -1;
        leak = 1'b0;
        drop = 1'b0;
        i1 = pat;
        q1.push_back(exp);
        pulse_start1();
        k = cyc;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            start1 = (restart && (t == 4 || t == 9)) ? 1'b1 : 1'b0;
            seen[s1] = 1'b1;
            if (!busy1) drop = 1'b1;
            if (done1) begin
                dcyc = cyc;
                break;
            end
            if (dout1 !== prev) leak = 1'b1;
        end
        start1 = 1'b0;
        check("scan1_done_edge", dcyc, k + 16);
        check("scan1_sel_visits", seen, 8'hFF);
        check("scan1_no_partial", leak, 1'b0);
        check("scan1_busy_held", drop, 1'b0);
        @(negedge clk);
        check("scan1_done_width", done1, 1'b0);
        check("scan1_idle_busy", busy1, 1'b0);
        check("scan1_idle_sel", s1, 3'd0);
    endtask

    task automatic run_scan3(input logic [7:0] pat);
        int dcyc;
        dcyc = -1;
        i3 = pat;
        q3.push_back(pat);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        k3 = cyc;
        poison3 = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done3) begin
                dcyc = cyc;
                break;
            end
        end
        check("scan3_done_edge", dcyc, k3 + 32);
        @(negedge clk);
        poison3 = 1'b0;
        check("scan3_done_width", done3, 1'b0);
        check("scan3_idle_busy", busy3, 1'b0);
    endtask

    typedef struct {
        logic [7:0] pat;
        bit         restart;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit found;
        int d1, d2, d3, k;

        vecs[0] = '{8'h5A, 1'b0, 8'h5A};
        vecs[1] = '{8'h00, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF};
        vecs[3] = '{8'h81, 1'b1, 8'h81};
        vecs[4] = '{8'hA5, 1'b0, 8'hA5};

        repeat (3) @(negedge clk);
        check("rst_sel", s1, 3'd0);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_data", dout1, 8'h00);
        check("rst_data3", dout3, 8'h00);
        rst_n = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start1 = 1'b1;
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        abort1 = 1'b0;
        @(negedge clk);
        check("start_abort_idle", busy1, 1'b0);

`ifdef MUX_SCAN_CONT_EN
        i1 = 8'hA5;
        q1.push_back(8'hA5);
        pulse_start1();
        k = cyc;
        d1 = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done1) begin d1 = cyc; break; end
        end
        check("cont_first_done", d1, k + 16);
        i1 = 8'h0F;
        q1.push_back(8'h0F);
        q1.push_back(8'h0F);
        @(negedge clk);
        check("cont_busy_held", busy1, 1'b1);
        d2 = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done1) begin d2 = cyc; break; end
        end
        // DONE occupies one cycle ahead of the rescan's first SETTLE
        check("cont_period_1", d2 - d1, 17);
        d3 = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done1) begin d3 = cyc; break; end
        end
        check("cont_period_2", d3 - d2, 17);
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        q1.delete();
        @(negedge clk);
        check("cont_abort_busy", busy1, 1'b0);
        check("cont_abort_data", dout1, 8'h0F);
`else
        for (int v = 0; v < 5; v++) begin
            run_scan1(vecs[v].pat, vecs[v].restart, vecs[v].exp);
            repeat (20) @(negedge clk);
        end

        run_scan3(8'h3C);
        check("scan3_data_hold", dout3, 8'h3C);
        run_scan3(8'hC3);

        // abort at S=3 after an 8'hA5 scan
        i1 = 8'hFF;
        pulse_start1();
        wait_sel1(3'd3, found);
        check("abort_reach_s3", found, 1'b1);
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        @(negedge clk);
        check("abort_busy", busy1, 1'b0);
        check("abort_sel", s1, 3'd0);
        check("abort_done", done1, 1'b0);
        check("abort_data", dout1, 8'hA5);
        repeat (30) @(negedge clk);
        check("abort_stays_idle", busy1, 1'b0);

        // asynchronous reset while S=5
        i1 = 8'h96;
        pulse_start1();
        wait_sel1(3'd5, found);
        check("reset_reach_s5", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_sel", s1, 3'd0);
        check("reset_busy", busy1, 1'b0);
        check("reset_done", done1, 1'b0);
        check("reset_data", dout1, 8'h00);
        check("reset_data3", dout3, 8'h00);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_waits_start", busy1, 1'b0);
        run_scan1(8'h96, 1'b0, 8'h96);
        repeat (5) @(negedge clk);
`endif

        check("sb1_drained", q1.size(), 0);
        check("sb3_drained", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
